// File: rtl/complex_fir_stream.sv
// Pipelined complex FIR with loadable coefficient set, optional conjugate (matched-filter)
// coefficients, valid handshakes and a zero-sample tail flush after the stream stops.
module complex_fir_stream #(
    parameter int LENGTH      = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH + 1 + $clog2(LENGTH)
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          loadCoefficientsFlag,
    input  logic                          coeffInValid,
    input  logic signed [COEFF_WIDTH-1:0] coefficientInI,
    input  logic signed [COEFF_WIDTH-1:0] coefficientInQ,
    input  logic                          conjMode,
    input  logic                          dataInValid,
    input  logic signed [DATA_WIDTH-1:0]  dataInI,
    input  logic signed [DATA_WIDTH-1:0]  dataInQ,
    input  logic                          stopDataLoadFlag,
    output logic signed [OUT_WIDTH-1:0]   dataOutI,
    output logic signed [OUT_WIDTH-1:0]   dataOutQ,
    output logic                          dataOutValid,
    output logic                          coeffLoadDone,
    output logic                          busy
);

    localparam int SUM_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH);
    localparam int CNT_WIDTH = $clog2(LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEFFICIENTS,
        FILTER,
        FLUSH,
        DONE
    } state_t;

    state_t                        state_q;
    logic [CNT_WIDTH-1:0]          coefCnt_q;
    logic [CNT_WIDTH-1:0]          flushCnt_q;
    logic                          conj_q;
    logic                          busy_q;
    logic                          loadDone_q;

    logic signed [COEFF_WIDTH-1:0] coefI_q [LENGTH];
    logic signed [COEFF_WIDTH-1:0] coefQ_q [LENGTH];
    logic signed [DATA_WIDTH-1:0]  dataI_q [LENGTH];
    logic signed [DATA_WIDTH-1:0]  dataQ_q [LENGTH];

    logic                          acceptValid_q;
    logic                          stage1Valid_q;
    logic                          outValid_q;
    logic signed [SUM_WIDTH-1:0]   sumII_d, sumQQ_d, sumIQ_d, sumQI_d;
    logic signed [SUM_WIDTH-1:0]   sumII_q, sumQQ_q, sumIQ_q, sumQI_q;
    logic signed [OUT_WIDTH-1:0]   outI_d, outQ_d;
    logic signed [OUT_WIDTH-1:0]   outI_q, outQ_q;

    logic                          coefAccept;
    logic                          loadComplete;
    logic                          shiftEn;
    logic                          pipeEmpty;
    logic signed [DATA_WIDTH-1:0]  shiftI, shiftQ;

    assign coefAccept   = (state_q == LOAD_COEFFICIENTS) && coeffInValid;
    assign loadComplete = coefAccept && (coefCnt_q == CNT_WIDTH'(LENGTH - 1));
    assign shiftEn      = ((state_q == FILTER) && dataInValid) || (state_q == FLUSH);
    assign shiftI       = (state_q == FLUSH) ? '0 : dataInI;
    assign shiftQ       = (state_q == FLUSH) ? '0 : dataInQ;
    // A new load may only start once no accepted sample is still inside the pipeline.
    assign pipeEmpty    = !acceptValid_q && !stage1Valid_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            coefCnt_q  <= '0;
            flushCnt_q <= '0;
            conj_q     <= 1'b0;
            busy_q     <= 1'b0;
            loadDone_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (loadCoefficientsFlag && pipeEmpty) begin
                        state_q    <= LOAD_COEFFICIENTS;
                        coefCnt_q  <= '0;
                        busy_q     <= 1'b1;
                        loadDone_q <= 1'b0;
                    end
                end
                LOAD_COEFFICIENTS: begin
                    if (loadComplete) begin
                        state_q    <= FILTER;
                        conj_q     <= conjMode;
                        loadDone_q <= 1'b1;
                    end else if (coefAccept) begin
                        coefCnt_q <= coefCnt_q + CNT_WIDTH'(1);
                    end
                end
                FILTER: begin
                    if (stopDataLoadFlag) begin
                        state_q    <= FLUSH;
                        flushCnt_q <= '0;
                    end
                end
                FLUSH: begin
                    if (flushCnt_q == CNT_WIDTH'(LENGTH - 2)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        flushCnt_q <= flushCnt_q + CNT_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < LENGTH; i++) begin
                coefI_q[i] <= '0;
                coefQ_q[i] <= '0;
            end
        end else if (coefAccept) begin
            coefI_q[coefCnt_q] <= coefficientInI;
            coefQ_q[coefCnt_q] <= coefficientInQ;
        end
    end

    // Delay line starts empty for every new coefficient set so old samples never leak in.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < LENGTH; i++) begin
                dataI_q[i] <= '0;
                dataQ_q[i] <= '0;
            end
        end else if (loadComplete) begin
            for (int i = 0; i < LENGTH; i++) begin
                dataI_q[i] <= '0;
                dataQ_q[i] <= '0;
            end
        end else if (shiftEn) begin
            dataI_q[0] <= shiftI;
            dataQ_q[0] <= shiftQ;
            for (int i = 1; i < LENGTH; i++) begin
                dataI_q[i] <= dataI_q[i-1];
                dataQ_q[i] <= dataQ_q[i-1];
            end
        end
    end

    always_comb begin
        sumII_d = '0;
        sumQQ_d = '0;
        sumIQ_d = '0;
        sumQI_d = '0;
        for (int i = 0; i < LENGTH; i++) begin
            sumII_d = sumII_d + SUM_WIDTH'(dataI_q[i]) * SUM_WIDTH'(coefI_q[i]);
            sumQQ_d = sumQQ_d + SUM_WIDTH'(dataQ_q[i]) * SUM_WIDTH'(coefQ_q[i]);
            sumIQ_d = sumIQ_d + SUM_WIDTH'(dataI_q[i]) * SUM_WIDTH'(coefQ_q[i]);
            sumQI_d = sumQI_d + SUM_WIDTH'(dataQ_q[i]) * SUM_WIDTH'(coefI_q[i]);
        end
    end

    // Conjugate coefficients flip the sign of every term that carries the coefficient's Q part.
    always_comb begin
        outI_d = '0;
        outQ_d = '0;
        if (conj_q) begin
            outI_d = OUT_WIDTH'(sumII_q) + OUT_WIDTH'(sumQQ_q);
            outQ_d = OUT_WIDTH'(sumQI_q) - OUT_WIDTH'(sumIQ_q);
        end else begin
            outI_d = OUT_WIDTH'(sumII_q) - OUT_WIDTH'(sumQQ_q);
            outQ_d = OUT_WIDTH'(sumIQ_q) + OUT_WIDTH'(sumQI_q);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acceptValid_q <= 1'b0;
            stage1Valid_q <= 1'b0;
            outValid_q    <= 1'b0;
            sumII_q       <= '0;
            sumQQ_q       <= '0;
            sumIQ_q       <= '0;
            sumQI_q       <= '0;
            outI_q        <= '0;
            outQ_q        <= '0;
        end else begin
            acceptValid_q <= shiftEn;
            stage1Valid_q <= acceptValid_q;
            outValid_q    <= stage1Valid_q;
            if (acceptValid_q) begin
                sumII_q <= sumII_d;
                sumQQ_q <= sumQQ_d;
                sumIQ_q <= sumIQ_d;
                sumQI_q <= sumQI_d;
            end
            if (stage1Valid_q) begin
                outI_q <= outI_d;
                outQ_q <= outQ_d;
            end
        end
    end

    assign dataOutI      = outI_q;
    assign dataOutQ      = outQ_q;
    assign dataOutValid  = outValid_q;
    assign coeffLoadDone = loadDone_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_complex_fir_stream.sv
// Self-checking bench for complex_fir_stream: a LENGTH=4 instance and a default instance share stimulus;
// results are compared against a complex convolution model with expected arrival cycles.
module tb_complex_fir_stream;

    logic              clock = 1'b0;
    logic              resetN = 1'b1;
    logic              loadCoefficientsFlag;
    logic              coeffInValid;
    logic signed [7:0] coefficientInI;
    logic signed [7:0] coefficientInQ;
    logic              conjMode;
    logic              dataInValid;
    logic signed [7:0] dataInI;
    logic signed [7:0] dataInQ;
    logic              stopDataLoadFlag;

    logic signed [18:0] s4I, s4Q;
    logic               s4V, s4Done, s4Busy;
    logic signed [20:0] s10I, s10Q;
    logic               s10V, s10Done, s10Busy;

    bit                 useLong;
    logic signed [20:0] actI, actQ;
    logic               actV, actDone, actBusy;

    int     checksPassed = 0;
    int     checksTotal  = 0;
    longint cyc          = 0;

    int     modelLen;
    int     coefTabI[10], coefTabQ[10];
    int     mCoefI[10], mCoefQ[10];
    bit     mConj;
    int     histI[$], histQ[$];
    longint expI[$], expQ[$], expCyc[$];
    longint obsI[$], obsQ[$];
    int     refI[4], refQ[4];
    int     accepted;

    complex_fir_stream #(.LENGTH(4)) dut4 (
        .clock(clock), .resetN(resetN),
        .loadCoefficientsFlag(loadCoefficientsFlag), .coeffInValid(coeffInValid),
        .coefficientInI(coefficientInI), .coefficientInQ(coefficientInQ), .conjMode(conjMode),
        .dataInValid(dataInValid), .dataInI(dataInI), .dataInQ(dataInQ),
        .stopDataLoadFlag(stopDataLoadFlag),
        .dataOutI(s4I), .dataOutQ(s4Q), .dataOutValid(s4V),
        .coeffLoadDone(s4Done), .busy(s4Busy)
    );

    complex_fir_stream dut10 (
        .clock(clock), .resetN(resetN),
        .loadCoefficientsFlag(loadCoefficientsFlag), .coeffInValid(coeffInValid),
        .coefficientInI(coefficientInI), .coefficientInQ(coefficientInQ), .conjMode(conjMode),
        .dataInValid(dataInValid), .dataInI(dataInI), .dataInQ(dataInQ),
        .stopDataLoadFlag(stopDataLoadFlag),
        .dataOutI(s10I), .dataOutQ(s10Q), .dataOutValid(s10V),
        .coeffLoadDone(s10Done), .busy(s10Busy)
    );

    assign actI    = useLong ? s10I : 21'(s4I);
    assign actQ    = useLong ? s10Q : 21'(s4Q);
    assign actV    = useLong ? s10V : s4V;
    assign actDone = useLong ? s10Done : s4Done;
    assign actBusy = useLong ? s10Busy : s4Busy;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint got, input longint want);
        checksTotal++;
        if (got == want) checksPassed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    // Every valid result must match the oldest outstanding expectation, including its arrival cycle.
    always @(negedge clock) begin
        if (actV) begin
            if (expI.size() == 0) begin
                checkOutput("spuriousValid", 1, 0);
            end else begin
                checkOutput("dataOutI", actI, expI.pop_front());
                checkOutput("dataOutQ", actQ, expQ.pop_front());
                checkOutput("latency", cyc, expCyc.pop_front());
            end
            obsI.push_back(actI);
            obsQ.push_back(actQ);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void modelAccept(input int xi, input int xq, input longint when);
        longint yI, yQ, xr, xm, hr, hq;
        int n;
        yI = 0;
        yQ = 0;
        histI.push_back(xi);
        histQ.push_back(xq);
        n = histI.size() - 1;
        for (int i = 0; i < modelLen; i++) begin
            if (n - i >= 0) begin
                xr = histI[n-i];
                xm = histQ[n-i];
                hr = mCoefI[i];
                hq = mConj ? -mCoefQ[i] : mCoefQ[i];
                yI += xr * hr - xm * hq;
                yQ += xr * hq + xm * hr;
            end
        end
        expI.push_back(yI);
        expQ.push_back(yQ);
        expCyc.push_back(when);
    endfunction

    function automatic void clearModel();
        expI.delete();
        expQ.delete();
        expCyc.delete();
        histI.delete();
        histQ.delete();
        obsI.delete();
        obsQ.delete();
    endfunction

    task automatic randomCoeffs();
        for (int i = 0; i < 10; i++) begin
            coefTabI[i] = int'($urandom_range(0, 255)) - 128;
            coefTabQ[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic loadCoeffs(input bit conj, input bit gaps);
        bit started;
        started = 1'b0;
        loadCoefficientsFlag = 1'b1;
        for (int t = 0; t < 40 && !started; t++) begin
            tick();
            started = actBusy;
        end
        checkOutput("loadStart", started, 1);
        loadCoefficientsFlag = 1'b0;
        conjMode = conj;
        for (int k = 0; k < modelLen; k++) begin
            if (gaps) begin
                coeffInValid   = 1'b0;
                coefficientInI = 8'($urandom);
                coefficientInQ = 8'($urandom);
                tick();
            end
            coeffInValid   = 1'b1;
            coefficientInI = 8'(coefTabI[k]);
            coefficientInQ = 8'(coefTabQ[k]);
            tick();
            if (k == modelLen - 2) checkOutput("doneEarly", actDone, 0);
        end
        checkOutput("loadDone", actDone, 1);
        checkOutput("busyFilter", actBusy, 1);
        if (gaps) begin
            coefficientInI = 8'($urandom);
            coefficientInQ = 8'($urandom);
            tick();
        end
        coeffInValid = 1'b0;
        conjMode     = ~conj;
        for (int i = 0; i < modelLen; i++) begin
            mCoefI[i] = coefTabI[i];
            mCoefQ[i] = coefTabQ[i];
        end
        mConj = conj;
        clearModel();
    endtask

    task automatic sendSample(input int xi, input int xq, input bit valid, input bit stop);
        dataInValid      = valid;
        dataInI          = 8'(xi);
        dataInQ          = 8'(xq);
        stopDataLoadFlag = stop;
        if (valid) modelAccept(xi, xq, cyc + 3);
        if (stop) begin
            for (int j = 1; j < modelLen; j++) modelAccept(0, 0, cyc + 3 + j);
        end
        tick();
        dataInValid      = 1'b0;
        stopDataLoadFlag = 1'b0;
        dataInI          = 8'($urandom);
        dataInQ          = 8'($urandom);
    endtask

    task automatic drainAndCheck();
        for (int t = 0; t < 80 && expI.size() != 0; t++) tick();
        checkOutput("drainEmpty", expI.size(), 0);
        tick();
        tick();
        checkOutput("doneBusy", actBusy, 0);
        checkOutput("doneLoadDone", actDone, 1);
    endtask

    task automatic applyStimulus(input int n, input bit lastValid, output int nAcc);
        bit v;
        nAcc = 0;
        for (int i = 0; i < n; i++) begin
            v = (i == n - 1) ? lastValid : ($urandom_range(0, 3) != 0);
            if (v) nAcc++;
            sendSample(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                       v, i == n - 1);
        end
        drainAndCheck();
        checkOutput("resultCount", obsI.size(), nAcc + modelLen - 1);
    endtask

    task automatic checkImpulse(input string tag);
        checkOutput($sformatf("%s.count", tag), obsI.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s.I%0d", tag, i), obsI[i], refI[i]);
            checkOutput($sformatf("%s.Q%0d", tag, i), obsQ[i], refQ[i]);
        end
    endtask

    task automatic doReset();
        resetN = 1'b0;
        #1;
        clearModel();
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic scenarioOneImpulse(input string tag);
        coefTabI[0] = 1;  coefTabQ[0] = 2;
        coefTabI[1] = 3;  coefTabQ[1] = -1;
        coefTabI[2] = 0;  coefTabQ[2] = 4;
        coefTabI[3] = -5; coefTabQ[3] = 0;
        loadCoeffs(1'b0, 1'b0);
        sendSample(1, 0, 1'b1, 1'b0);
        sendSample(0, 0, 1'b0, 1'b1);
        drainAndCheck();
        refI = '{1, 3, 0, -5};
        refQ = '{2, -1, 4, 0};
        checkImpulse(tag);
    endtask

    initial begin
        loadCoefficientsFlag = 1'b0;
        coeffInValid         = 1'b0;
        coefficientInI       = '0;
        coefficientInQ       = '0;
        conjMode             = 1'b0;
        dataInValid          = 1'b0;
        dataInI              = '0;
        dataInQ              = '0;
        stopDataLoadFlag     = 1'b0;
        useLong              = 1'b1;
        modelLen             = 10;

        #1 resetN = 1'b0;
        #2;
        checkOutput("rst4.I", s4I, 0);
        checkOutput("rst4.valid", s4V, 0);
        checkOutput("rst4.busy", s4Busy, 0);
        checkOutput("rst4.done", s4Done, 0);
        checkOutput("rst10.Q", s10Q, 0);
        checkOutput("rst10.valid", s10V, 0);
        checkOutput("rst10.busy", s10Busy, 0);
        checkOutput("rst10.done", s10Done, 0);
        tick();
        resetN = 1'b1;
        tick();

        // Full-scale corner at default size: the 21-bit output must hold the extreme sum exactly.
        for (int i = 0; i < 10; i++) begin
            coefTabI[i] = -128;
            coefTabQ[i] = -128;
        end
        loadCoeffs(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) sendSample(-128, -128, 1'b1, 1'b0);
        sendSample(0, 0, 1'b0, 1'b1);
        drainAndCheck();
        checkOutput("fullScale.count", obsI.size(), 21);
        checkOutput("fullScale.I", obsI[11], 0);
        checkOutput("fullScale.Q", obsQ[11], 327680);
        loadCoeffs(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) sendSample(-128, -128, 1'b1, 1'b0);
        sendSample(0, 0, 1'b0, 1'b1);
        drainAndCheck();
        checkOutput("fullScaleConj.I", obsI[11], 327680);
        checkOutput("fullScaleConj.Q", obsQ[11], 0);

        doReset();
        useLong  = 1'b0;
        modelLen = 4;

        scenarioOneImpulse("impulseReal");

        loadCoeffs(1'b0, 1'b0);
        sendSample(0, 1, 1'b1, 1'b0);
        sendSample(0, 0, 1'b0, 1'b1);
        drainAndCheck();
        refI = '{-2, 1, -4, 0};
        refQ = '{1, 3, 0, -5};
        checkImpulse("impulseImag");

        loadCoeffs(1'b1, 1'b0);
        sendSample(1, 0, 1'b1, 1'b0);
        sendSample(0, 0, 1'b0, 1'b1);
        drainAndCheck();
        refI = '{1, 3, 0, -5};
        refQ = '{-2, 1, -4, 0};
        checkImpulse("impulseConj");

        randomCoeffs();
        loadCoeffs(1'($urandom), 1'b1);
        applyStimulus(15, 1'b1, accepted);

        // Reset while filtering must clear outputs and status immediately, without a clock edge.
        scenarioOneImpulse("beforeReset");
        loadCoeffs(1'b0, 1'b0);
        sendSample(7, -3, 1'b1, 1'b0);
        sendSample(-20, 11, 1'b1, 1'b0);
        sendSample(5, 9, 1'b1, 1'b0);
        resetN = 1'b0;
        #1;
        checkOutput("midReset.I", actI, 0);
        checkOutput("midReset.Q", actQ, 0);
        checkOutput("midReset.valid", actV, 0);
        checkOutput("midReset.busy", actBusy, 0);
        checkOutput("midReset.done", actDone, 0);
        clearModel();
        tick();
        resetN = 1'b1;
        tick();
        scenarioOneImpulse("afterReset");

        for (int r = 0; r < 4; r++) begin
            randomCoeffs();
            loadCoeffs(1'($urandom), 1'($urandom));
            applyStimulus(12 + int'($urandom_range(0, 10)), 1'($urandom), accepted);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
